// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared definitions for the LED pattern controller.
// Holds mode and time-unit codes, readback frame header bytes, reset
// defaults, readback FSM state encoding and the pattern helper functions.
package led_ctrl_pkg;

  typedef enum logic [3:0] {
    MODE_OFF   = 4'd0,
    MODE_ON    = 4'd1,
    MODE_ROT_L = 4'd2,
    MODE_ROT_R = 4'd3,
    MODE_BLINK = 4'd4,
    MODE_COUNT = 4'd5
  } led_mode_e;

  typedef enum logic [3:0] {
    UNIT_1MS   = 4'd0,
    UNIT_10MS  = 4'd1,
    UNIT_100MS = 4'd2,
    UNIT_1S    = 4'd3
  } time_unit_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } rb_state_e;

  localparam logic [3:0] MODE_MAX = 4'd5;
  localparam logic [3:0] UNIT_MAX = 4'd3;

  localparam logic [7:0] HDR_MODE = 8'hA1;
  localparam logic [7:0] HDR_TIME = 8'hA2;

  localparam led_mode_e  RST_MODE      = MODE_OFF;
  localparam logic [7:0] RST_TIME_NUM  = 8'd10;
  localparam logic [3:0] RST_TIME_UNIT = 4'd2;

  // WAIT_BUSY down-counter load: 15..0 gives a 16-cycle busy timeout
  localparam logic [3:0] BUSY_TMO_LOAD = 4'd15;

  // Last count of the ms counter for one unit (unit length minus one).
  function automatic logic [9:0] unit_last(input logic [3:0] code);
    case (code)
      UNIT_1MS:   return 10'd0;
      UNIT_10MS:  return 10'd9;
      UNIT_100MS: return 10'd99;
      UNIT_1S:    return 10'd999;
      default:    return 10'd0;
    endcase
  endfunction

  function automatic logic [3:0] start_pattern(input led_mode_e m);
    case (m)
      MODE_ON, MODE_BLINK: return 4'b1111;
      MODE_ROT_L:          return 4'b0001;
      MODE_ROT_R:          return 4'b1000;
      default:             return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] next_pattern(input led_mode_e m, input logic [3:0] cur);
    case (m)
      MODE_ROT_L: return {cur[2:0], cur[3]};
      MODE_ROT_R: return {cur[0], cur[3:1]};
      MODE_BLINK: return ~cur;
      MODE_COUNT: return cur + 4'd1;
      default:    return cur;
    endcase
  endfunction

endpackage

// File: rtl/led_ctrl_tick.sv
// led_tick_gen: step-period timer for led_ctrl.
// Chain of three up-counters: a CLK_HZ/1000 prescaler giving a 1 ms tick,
// a unit counter (1/10/100/1000 ms) and a time_num counter (0 treated as 1).
// step is a one-cycle pulse at the end of each full step period.
// Ports:
//   clk, reset (async, active low), clear (restart the period from zero)
//   time_num [7:0], time_unit [3:0]   current step-period settings
//   step                              one-cycle pulse per step period
module led_tick_gen
  import led_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [7:0] time_num,
  input  logic [3:0] time_unit,
  output logic       step
);

  localparam int PRE_CNT = CLK_HZ / 1000;
  localparam int PRE_W   = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_CNT - 1);

  logic [PRE_W-1:0] pre_q;
  logic [9:0]       unit_q;
  logic [7:0]       num_q;
  logic [7:0]       num_last;
  logic             ms_tick;
  logic             unit_tick;

  // The settings registers only change together with clear, so the
  // counters can never sit beyond these terminal counts.
  assign num_last  = (time_num == 8'd0) ? 8'd0 : time_num - 8'd1;
  assign ms_tick   = (pre_q == PRE_LAST);
  assign unit_tick = ms_tick && (unit_q == unit_last(time_unit));
  assign step      = unit_tick && (num_q == num_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q  <= '0;
      unit_q <= '0;
      num_q  <= '0;
    end else if (clear) begin
      pre_q  <= '0;
      unit_q <= '0;
      num_q  <= '0;
    end else begin
      pre_q <= ms_tick ? '0 : pre_q + 1'b1;
      if (ms_tick) unit_q <= unit_tick ? '0 : unit_q + 10'd1;
      if (unit_tick) num_q <= step ? '0 : num_q + 8'd1;
    end
  end

endmodule

// File: rtl/led_ctrl.sv
// led_ctrl: 4-LED pattern sequencer with optional UART readback of settings.
// Ports:
//   clk, reset (async, active low)
//   time_control_en, time_num [7:0], time_unit [3:0]  step-period setting strobe
//   led_mode_en, led_mode [3:0]                        pattern mode strobe
//   rd_led_mode_en, rd_led_time_en                     readback requests
//   tx_busy                                            UART transmitter busy
//   din_v, din [7:0]                                   byte to UART transmitter
//   led_out [3:0]                                      LED drive, 1 = on
// Build option: LED_CTRL_READBACK_EN enables the readback FSM; without it
// the read requests and tx_busy are ignored and din_v/din are held at zero.
//
// Readback FSM:
//   state     | meaning
//   IDLE      | nothing in flight, waiting for a pending request
//   LOAD      | snapshot the selected frame's bytes
//   SEND      | issue the current byte once tx_busy is low
//   WAIT_BUSY | wait for the transmitter to go busy (16-cycle timeout)
//   WAIT_DONE | wait for the transmitter to finish, then next byte or IDLE
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       time_control_en,
  input  logic [7:0] time_num,
  input  logic [3:0] time_unit,
  input  logic       led_mode_en,
  input  logic [3:0] led_mode,
  input  logic       rd_led_mode_en,
  input  logic       rd_led_time_en,
  input  logic       tx_busy,
  output logic       din_v,
  output logic [7:0] din,
  output logic [3:0] led_out
);

  led_mode_e  mode_q;
  logic [7:0] num_q;
  logic [3:0] unit_q;
  logic       mode_ok;
  logic       time_ok;
  logic       clear;
  logic       step;

  assign mode_ok = led_mode_en && (led_mode <= MODE_MAX);
  assign time_ok = time_control_en && (time_unit <= UNIT_MAX);
  assign clear   = mode_ok || time_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= RST_MODE;
      num_q   <= RST_TIME_NUM;
      unit_q  <= RST_TIME_UNIT;
      led_out <= 4'b0000;
    end else begin
      if (time_ok) begin
        num_q  <= time_num;
        unit_q <= time_unit;
      end
      // A mode load wins over a coinciding step advance.
      if (mode_ok) begin
        mode_q  <= led_mode_e'(led_mode);
        led_out <= start_pattern(led_mode_e'(led_mode));
      end else if (step) begin
        led_out <= next_pattern(mode_q, led_out);
      end
    end
  end

  led_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .time_num  (num_q),
    .time_unit (unit_q),
    .step      (step)
  );

`ifdef LED_CTRL_READBACK_EN
  rb_state_e       state_q, state_d;
  logic            pend_mode_q, pend_time_q;
  logic            sel_time_q;
  logic [2:0][7:0] frame_q;
  logic [1:0]      idx_q, last_q;
  logic [3:0]      tmo_q;
  logic            enter_load;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (pend_mode_q || pend_time_q) state_d = ST_LOAD;
      ST_LOAD:      state_d = ST_SEND;
      ST_SEND:      if (!tx_busy) state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy || (tmo_q == 4'd0)) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) state_d = (idx_q == last_q) ? ST_IDLE : ST_SEND;
      default:      state_d = ST_IDLE;
    endcase
  end

  assign enter_load = (state_q == ST_IDLE) && (state_d == ST_LOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pend_mode_q <= 1'b0;
      pend_time_q <= 1'b0;
      sel_time_q  <= 1'b0;
      frame_q     <= '0;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      tmo_q       <= 4'd0;
      din_v       <= 1'b0;
      din         <= 8'h00;
    end else begin
      state_q <= state_d;
      din_v   <= 1'b0;
      // Mode requests are served first; a new strobe on the clearing edge
      // re-arms the flag so it is not lost.
      pend_mode_q <= rd_led_mode_en || (pend_mode_q && !enter_load);
      pend_time_q <= rd_led_time_en || (pend_time_q && !(enter_load && !pend_mode_q));
      if (enter_load) sel_time_q <= !pend_mode_q;
      case (state_q)
        ST_LOAD: begin
          frame_q <= sel_time_q ? {{4'h0, unit_q}, num_q, HDR_TIME}
                                : {8'h00, {4'h0, mode_q}, HDR_MODE};
          idx_q   <= 2'd0;
          last_q  <= sel_time_q ? 2'd2 : 2'd1;
        end
        ST_SEND: begin
          if (!tx_busy) begin
            din   <= frame_q[idx_q];
            din_v <= 1'b1;
            tmo_q <= BUSY_TMO_LOAD;
          end
        end
        ST_WAIT_BUSY: begin
          if (!tx_busy && (tmo_q != 4'd0)) tmo_q <= tmo_q - 4'd1;
        end
        ST_WAIT_DONE: begin
          if (!tx_busy && (idx_q != last_q)) idx_q <= idx_q + 2'd1;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_readback;
  assign unused_readback = rd_led_mode_en ^ rd_led_time_en ^ tx_busy;
  assign din_v = 1'b0;
  assign din   = 8'h00;
`endif

endmodule

// File: tb/tb_led_ctrl.sv
module tb_led_ctrl;

  localparam int CLK_HZ     = 4000;
  localparam int CYC_PER_MS = CLK_HZ / 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       time_control_en = 1'b0;
  logic [7:0] time_num = 8'd0;
  logic [3:0] time_unit = 4'd0;
  logic       led_mode_en = 1'b0;
  logic [3:0] led_mode = 4'd0;
  logic       rd_led_mode_en = 1'b0;
  logic       rd_led_time_en = 1'b0;
  logic       tx_busy;
  logic       din_v;
  logic [7:0] din;
  logic [3:0] led_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_ctrl #(.CLK_HZ(CLK_HZ)) dut (
    .clk             (clk),
    .reset           (reset),
    .time_control_en (time_control_en),
    .time_num        (time_num),
    .time_unit       (time_unit),
    .led_mode_en     (led_mode_en),
    .led_mode        (led_mode),
    .rd_led_mode_en  (rd_led_mode_en),
    .rd_led_time_en  (rd_led_time_en),
    .tx_busy         (tx_busy),
    .din_v           (din_v),
    .din             (din),
    .led_out         (led_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  int         m_mode = 0;
  int         m_num = 10;
  int         m_unit = 2;
  logic [3:0] m_led = 4'b0000;
  int         m_elapsed = 0;   // edges since the period last restarted

  function automatic int period_cycles(input int num, input int unit);
    int ms;
    ms = (unit == 0) ? 1 : (unit == 1) ? 10 : (unit == 2) ? 100 : 1000;
    return ((num == 0) ? 1 : num) * ms * CYC_PER_MS;
  endfunction

  function automatic logic [3:0] model_start(input int mode);
    case (mode)
      1, 4:    return 4'hF;
      2:       return 4'h1;
      3:       return 4'h8;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] model_advance(input int mode, input logic [3:0] v);
    int x;
    x = int'(v);
    case (mode)
      2:       return 4'(((x * 2) | (x / 8)) % 16);
      3:       return 4'((x / 2) | ((x % 2) * 8));
      4:       return 4'(15 - x);
      5:       return 4'((x + 1) % 16);
      default: return v;
    endcase
  endfunction

  initial begin : model
    bit step, mok, tok;
    forever begin
      @(posedge clk);
      if (reset !== 1'b1) begin
        m_mode = 0; m_num = 10; m_unit = 2; m_led = 4'h0; m_elapsed = 0;
      end else begin
        step = (m_elapsed + 1 == period_cycles(m_num, m_unit));
        mok  = led_mode_en && (int'(led_mode) <= 5);
        tok  = time_control_en && (int'(time_unit) <= 3);
        if (mok) m_led = model_start(int'(led_mode));
        else if (step) m_led = model_advance(m_mode, m_led);
        if (mok || tok || step) m_elapsed = 0;
        else m_elapsed++;
        if (tok) begin m_num = int'(time_num); m_unit = int'(time_unit); end
        if (mok) m_mode = int'(led_mode);
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (reset === 1'b1) check("led_out_vs_model", 32'(led_out), 32'(m_led));
    end
  end

  // ---------------- UART side: byte collector and busy model ----------------
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         dv_count = 0;
  int         cyc = 0;
  bit         busy_en = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : collector
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
`ifndef LED_CTRL_READBACK_EN
        check("din_v_tied_low", 32'(din_v), 32'd0);
        check("din_tied_zero", 32'(din), 32'd0);
`endif
        if (din_v === 1'b1) begin
          rx_q.push_back(din);
          rx_t.push_back(cyc);
          dv_count++;
        end
      end
    end
  end

  // Transmitter goes busy one cycle after each din_v and stays busy 10 cycles.
  initial begin : busy_drv
    int last, left;
    last = 0;
    left = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (busy_en && (dv_count != last)) left = 10;
      last = dv_count;
      tx_busy = busy_en && (left > 0);
      if (left > 0) left--;
    end
  end

  task automatic wait_rx(input int n, input int limit, input string name);
    int k;
    k = 0;
    while ((rx_q.size() < n) && (k < limit)) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp[$], input int limit);
    wait_rx(exp.size(), limit, {name, "_arrive"});
    repeat (60) @(negedge clk);
    check({name, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
    foreach (exp[i])
      check($sformatf("%s_byte%0d", name, i),
            (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD, 32'(exp[i]));
  endtask

  task automatic set_cfg(input int mode, input int num, input int unit);
    tick();
    led_mode_en = 1'b1; led_mode = 4'(mode);
    time_control_en = 1'b1; time_num = 8'(num); time_unit = 4'(unit);
    tick();
    led_mode_en = 1'b0; time_control_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [7:0] e[$];
    repeat (5) tick();
    reset = 1'b1;
    @(negedge clk);
    check("reset_led_out", 32'(led_out), 32'h0);
    check("reset_din_v", 32'(din_v), 32'h0);
    check("reset_din", 32'(din), 32'h0);
    repeat (50) @(negedge clk);
    check("mode0_idle_led", 32'(led_out), 32'h0);

    // rotate left, 3 x 1 ms = 12 cycles per step, both strobes together
    set_cfg(2, 3, 0);
    @(negedge clk);
    check("rotl_load", 32'(led_out), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] prev, nxt;
      prev = 4'(1 << ((k - 1) % 4));
      nxt  = 4'(1 << (k % 4));
      repeat (11) @(negedge clk);
      check($sformatf("rotl_hold%0d", k), 32'(led_out), 32'(prev));
      @(negedge clk);
      check($sformatf("rotl_step%0d", k), 32'(led_out), 32'(nxt));
    end
    check("model_pin_rotl", 32'(m_led), 32'h1);

    // binary count, time_num 0 treated as 1 -> step every 4 cycles
    set_cfg(5, 0, 0);
    @(negedge clk);
    check("count_load", 32'(led_out), 32'h0);
    for (int k = 1; k <= 20; k++) begin
      if (k == 6) begin
        time_control_en = 1'b1; time_unit = 4'd7; time_num = 8'd200;
        led_mode_en = 1'b1; led_mode = 4'd9;
      end
      repeat (3) begin
        @(negedge clk);
        time_control_en = 1'b0;
        led_mode_en = 1'b0;
      end
      check($sformatf("count_hold%0d", k), 32'(led_out), 32'((k - 1) % 16));
      @(negedge clk);
      check($sformatf("count_step%0d", k), 32'(led_out), 32'(k % 16));
    end
    check("model_pin_count", 32'(m_led), 32'h4);

    // randomized settings traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      tick();
      led_mode_en = ($urandom_range(0, 39) == 0);
      led_mode = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      time_control_en = ($urandom_range(0, 59) == 0);
      time_num = 8'($urandom_range(0, 6));
      r = $urandom_range(0, 9);
      time_unit = (r < 6) ? 4'd0 : (r < 8) ? 4'd1 : (r == 8) ? 4'($urandom_range(4, 15)) : 4'd2;
    end
    tick();
    led_mode_en = 1'b0;
    time_control_en = 1'b0;

`ifdef LED_CTRL_READBACK_EN
    set_cfg(5, 3, 0);
    busy_en = 1'b1;
    rx_q.delete(); rx_t.delete();
    tick();
    rd_led_mode_en = 1'b1; rd_led_time_en = 1'b1;
    tick();
    rd_led_mode_en = 1'b0; rd_led_time_en = 1'b0;
    e = {8'hA1, 8'h05, 8'hA2, 8'h03, 8'h00};
    check_rx("rb_both", e, 1000);

    // snapshot held while settings change; repeated mode requests merge
    rx_q.delete(); rx_t.delete();
    tick();
    rd_led_time_en = 1'b1;
    tick();
    rd_led_time_en = 1'b0;
    wait_rx(1, 200, "rb_snap_first");
    tick();
    time_control_en = 1'b1; time_num = 8'd7; time_unit = 4'd1;
    for (int j = 0; j < 3; j++) begin
      tick();
      time_control_en = 1'b0;
      rd_led_mode_en = 1'b1;
      tick();
      rd_led_mode_en = 1'b0;
    end
    e = {8'hA2, 8'h03, 8'h00, 8'hA1, 8'h05};
    check_rx("rb_snap_merge", e, 2000);

    rx_q.delete(); rx_t.delete();
    tick();
    rd_led_time_en = 1'b1;
    tick();
    rd_led_time_en = 1'b0;
    e = {8'hA2, 8'h07, 8'h01};
    check_rx("rb_new_time", e, 1000);

    // no busy response: 16 cycles in WAIT_BUSY, then one each in WAIT_DONE
    // and SEND, so consecutive din_v pulses are 18 cycles apart
    busy_en = 1'b0;
    rx_q.delete(); rx_t.delete();
    tick();
    rd_led_mode_en = 1'b1;
    tick();
    rd_led_mode_en = 1'b0;
    e = {8'hA1, 8'h05};
    check_rx("rb_timeout", e, 500);
    check("rb_timeout_gap", (rx_t.size() >= 2) ? 32'(rx_t[1] - rx_t[0]) : 32'hDEAD, 32'd18);

    // reset in the middle of a frame aborts it for good
    busy_en = 1'b1;
    rx_q.delete(); rx_t.delete();
    tick();
    rd_led_time_en = 1'b1;
    tick();
    rd_led_time_en = 1'b0;
    wait_rx(1, 200, "rb_abort_first");
    tick();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    @(negedge clk);
    check("abort_din_v", 32'(din_v), 32'h0);
    check("abort_din", 32'(din), 32'h0);
    check("abort_led_out", 32'(led_out), 32'h0);
    repeat (200) @(negedge clk);
    check("abort_no_more_bytes", 32'(rx_q.size()), 32'd1);
`else
    busy_en = 1'b1;
    tick();
    rd_led_mode_en = 1'b1; rd_led_time_en = 1'b1;
    tick();
    rd_led_mode_en = 1'b0; rd_led_time_en = 1'b0;
    repeat (60) @(negedge clk);
    check("no_readback_dv", 32'(dv_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
